// File: rtl/pinmux_handover_ctrl_pkg.sv
// pinmux_handover_ctrl_pkg: shared pinmux constants and handover sequencer state type
package pinmux_handover_ctrl_pkg;
  localparam int PINMUX_NUM_SEL = 5;
  localparam int INOUT_PIN_NUM = 68;
  localparam int OUT_PIN_NUM = 32;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } pinmux_hctrl_state_e;
endpackage

// File: rtl/pinmux_handover_ctrl.sv
// pinmux_handover_ctrl: glitch-free per-pin source-select change, pad tri-stated across the switch
module pinmux_handover_ctrl
  import pinmux_handover_ctrl_pkg::*;
#(
  parameter int NumPins     = INOUT_PIN_NUM,
  parameter int NumSel      = PINMUX_NUM_SEL,
  parameter int GuardCycles = 4,
  localparam int PinW       = $clog2(NumPins),
  localparam int SelW       = $clog2(NumSel)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PinW-1:0]         req_pin_i,
  input  logic [SelW-1:0]         req_sel_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_error_o,
  output logic [NumPins*SelW-1:0] pin_sel_o,
  output logic [NumPins-1:0]      pin_hold_o,
  output logic                    busy_o
);
  localparam int CntW = GuardCycles > 1 ? $clog2(GuardCycles) : 1;
  localparam logic [PinW:0] PinLim = (PinW+1)'(NumPins);
  localparam logic [SelW:0] SelLim = (SelW+1)'(NumSel);
  localparam logic [CntW-1:0] CntLoad = CntW'(GuardCycles - 1);
  if (GuardCycles < 1) begin : g_bad_guard
    $error("GuardCycles must be at least 1");
  end
  pinmux_hctrl_state_e        r_state;
  logic [PinW-1:0]            r_pin;
  logic [SelW-1:0]            r_sel;
  logic [CntW-1:0]            r_cnt;
  logic                       r_err;
  logic                       r_rsp_valid;
  logic [NumPins*SelW-1:0]    r_sel_q;
  logic [NumPins-1:0]         r_hold;
  logic                       w_accept;
  logic                       w_err;
  logic [SelW-1:0]            w_cur;
  assign w_accept = req_valid_i && r_state == ST_IDLE;
  assign w_err = {1'b0, req_pin_i} >= PinLim || {1'b0, req_sel_i} >= SelLim;
  assign w_cur = r_sel_q[int'(req_pin_i)*SelW +: SelW];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_pin       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_sel_q     <= '0;
      r_hold      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          // invalid or already-selected requests answer at once without touching the pad
          if (w_err || w_cur == req_sel_i) begin
            r_err       <= w_err;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_pin             <= req_pin_i;
            r_sel             <= req_sel_i;
            r_hold[req_pin_i] <= 1'b1;
            r_cnt             <= CntLoad;
            r_state           <= ST_HOLD;
          end
        end
        ST_HOLD: if (r_cnt == '0) begin
          r_sel_q[int'(r_pin)*SelW +: SelW] <= r_sel;
          r_state                           <= ST_COMMIT;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_COMMIT: begin
          r_hold      <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_err       <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end
  assign req_ready_o = r_state == ST_IDLE;
  assign busy_o      = r_state != ST_IDLE;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_error_o = r_err;
  assign pin_sel_o   = r_sel_q;
  assign pin_hold_o  = r_hold;
endmodule

// File: tb/tb_pinmux_handover_ctrl.sv
// tb_pinmux_handover_ctrl: random and directed checks against a cycle-offset reference model
module tb_pinmux_handover_ctrl;
  localparam int NP = 68;
  localparam int NS = 5;
  localparam int G  = 4;
  localparam int PW = 7;
  localparam int SW = 3;
  logic             clk;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [PW-1:0]    req_pin_i;
  logic [SW-1:0]    req_sel_i;
  logic             rsp_valid_o;
  logic             rsp_error_o;
  logic [NP*SW-1:0] pin_sel_o;
  logic [NP-1:0]    pin_hold_o;
  logic             busy_o;
  int n_chk, n_err;
  int cyc;
  int m_sel [NP];
  int t_acc, t_pin, t_sel, t_old;
  bit t_fast, t_err, acc_now;
  pinmux_handover_ctrl #(.NumPins(NP), .NumSel(NS), .GuardCycles(G)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_pin_i(req_pin_i), .req_sel_i(req_sel_i), .rsp_valid_o(rsp_valid_o),
    .rsp_error_o(rsp_error_o), .pin_sel_o(pin_sel_o), .pin_hold_o(pin_hold_o), .busy_o(busy_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [NP*SW-1:0] got, input logic [NP*SW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (m_sel[i]) m_sel[i] = 0;
    t_acc = -1;
  endtask
  function automatic int done_at();
    return t_acc < 0 ? 0 : t_acc + (t_fast ? 2 : G + 3);
  endfunction
  task automatic check_outputs();
    logic [NP*SW-1:0] es;
    logic [NP-1:0]    eh;
    logic             ev, ee, er, eb;
    int d;
    d  = cyc - t_acc;
    es = '0;
    eh = '0;
    foreach (m_sel[i]) es[i*SW +: SW] = m_sel[i][SW-1:0];
    ev = 1'b0;
    ee = 1'b0;
    er = cyc >= done_at();
    eb = !er;
    if (t_acc >= 0 && t_fast) begin
      ev = d == 1;
      ee = d == 1 && t_err;
    end else if (t_acc >= 0) begin
      if (d < G + 1) es[t_pin*SW +: SW] = t_old[SW-1:0];
      if (d >= 1 && d <= G + 1) eh[t_pin] = 1'b1;
      ev = d == G + 2;
    end
    chk("pin_sel", pin_sel_o, es);
    chk("pin_hold", {{(NP*SW-NP){1'b0}}, pin_hold_o}, {{(NP*SW-NP){1'b0}}, eh});
    chk("req_ready", {{(NP*SW-1){1'b0}}, req_ready_o}, {{(NP*SW-1){1'b0}}, er});
    chk("rsp_valid", {{(NP*SW-1){1'b0}}, rsp_valid_o}, {{(NP*SW-1){1'b0}}, ev});
    chk("rsp_error", {{(NP*SW-1){1'b0}}, rsp_error_o & rsp_valid_o}, {{(NP*SW-1){1'b0}}, ee});
    chk("busy", {{(NP*SW-1){1'b0}}, busy_o}, {{(NP*SW-1){1'b0}}, eb});
  endtask
  task automatic step(input bit v, input int p, input int s);
    @(negedge clk);
    check_outputs();
    req_valid_i = v;
    req_pin_i   = PW'(p);
    req_sel_i   = SW'(s);
    acc_now     = 1'b0;
    if (v && cyc >= done_at()) begin
      acc_now = 1'b1;
      t_acc   = cyc;
      t_pin   = p;
      t_sel   = s;
      t_err   = p >= NP || s >= NS;
      t_fast  = t_err || m_sel[p] == s;
      if (!t_fast) begin
        t_old    = m_sel[p];
        m_sel[p] = s;
      end
    end
    cyc++;
  endtask
  task automatic request(input int p, input int s);
    int tries;
    tries = 0;
    do begin
      step(1'b1, p, s);
      tries++;
    end while (!acc_now && tries < 30);
    if (!acc_now) chk("req_timeout", '0, 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask
  initial begin
    bit pend;
    int pp, ps;
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_pin_i = '0;
    req_sel_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_ni = 1'b1;
    idle(2);
    request(55, 2);
    request(10, 1);
    idle(8);
    request(68, 1);
    idle(2);
    request(3, 5);
    idle(2);
    request(55, 2);
    idle(2);
    request(20, 4);
    idle(3);
    #1 rst_ni = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_ni = 1'b1;
    idle(4);
    pend = 1'b0;
    pp = 0;
    ps = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pp = $urandom_range(0, 71);
        ps = $urandom_range(0, 2) == 0 && pp < NP ? m_sel[pp] : $urandom_range(0, 5);
      end
      step(pend, pp, ps);
      if (acc_now) pend = 1'b0;
    end
    idle(G + 4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
